hilo_muldiv_unit: RTL and testbench

//  Multi-cycle multiply/divide unit that owns the HI/LO special-register pair.

---
 rtl/hilo_muldiv_unit_pkg.sv | 28 ++
 rtl/hilo_muldiv_unit_divider.sv | 78 +++++++
 rtl/hilo_muldiv_unit.sv | 120 ++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and small op-class helpers.
package hilo_muldiv_unit_pkg;

  typedef enum logic [2:0] {
    HILO_OP_MULT  = 3'd0,
    HILO_OP_MULTU = 3'd1,
    HILO_OP_DIV   = 3'd2,
    HILO_OP_DIVU  = 3'd3,
    HILO_OP_MTHI  = 3'd4,
    HILO_OP_MTLO  = 3'd5
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } hilo_state_e;

  function automatic logic is_mul_op(input logic [2:0] code);
    return (code == HILO_OP_MULT) || (code == HILO_OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] code);
    return (code == HILO_OP_DIV) || (code == HILO_OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_divider.sv
// Radix-2 restoring divider on operand magnitudes: one load edge, DATA_BITS
// iteration edges, then quotient/remainder are presented with signs fixed up.
module hilo_muldiv_unit_divider #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic                 abort,
  input  logic [DATA_BITS-1:0] dividend,
  input  logic [DATA_BITS-1:0] divisor,
  output logic [DATA_BITS-1:0] quotient,
  output logic [DATA_BITS-1:0] remainder,
  output logic                 valid
);

  localparam int W     = DATA_BITS;
  localparam int CNT_W = $clog2(DATA_BITS + 2);

  logic               running_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*W-1:0]     acc_q;      // {partial remainder, dividend/quotient bits}
  logic [W-1:0]       divisor_q;
  logic               neg_quo_q;
  logic               neg_rem_q;

  logic               a_neg, b_neg;
  logic [W-1:0]       a_mag, b_mag;
  logic [2*W:0]       shifted;
  logic [W:0]         trial;
  logic [2*W-1:0]     acc_next;

  assign a_neg = is_signed && dividend[W-1];
  assign b_neg = is_signed && divisor[W-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  assign shifted  = {acc_q, 1'b0};
  assign trial    = shifted[2*W:W] - {1'b0, divisor_q};
  assign acc_next = trial[W] ? shifted[2*W-1:0]
                             : {trial[W-1:0], shifted[W-1:0] | W'(1)};

  assign valid     = running_q && (cnt_q == CNT_W'(DATA_BITS));
  assign quotient  = neg_quo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign remainder = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (abort) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      cnt_q     <= '0;
      acc_q     <= {{W{1'b0}}, a_mag};
      divisor_q <= b_mag;
      // Divide-by-zero keeps the all-ones quotient unsigned; remainder still follows the dividend.
      neg_quo_q <= (a_neg ^ b_neg) && (divisor != '0);
      neg_rem_q <= a_neg;
    end else if (running_q) begin
      if (valid) begin
        running_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO special-register pair with a multi-cycle multiplier and an iterative
// divider; busy stalls EX while an op is in flight, flush aborts it.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int DATA_BITS   = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [DATA_BITS-1:0] operand_a,
  input  logic [DATA_BITS-1:0] operand_b,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] hi,
  output logic [DATA_BITS-1:0] lo
);

  localparam int                CNT_W    = $clog2(DATA_BITS + 2);
  localparam logic [CNT_W-1:0]  MUL_LAST = CNT_W'(MUL_LATENCY - 1);

  hilo_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [2*DATA_BITS-1:0]   prod_q, prod_d;
  logic [2*DATA_BITS-1:0]   a_ext, b_ext;
  logic                     accept, div_start, mul_signed;
  logic                     div_valid;
  logic [DATA_BITS-1:0]     div_quo, div_rem;

  assign busy       = (state_q != ST_IDLE);
  assign accept     = start && !busy && !flush;
  assign div_start  = accept && is_div_op(op);
  assign mul_signed = (op == HILO_OP_MULT);

  // Extending both operands to full width makes one unsigned multiply serve MULT and MULTU.
  assign a_ext  = {{DATA_BITS{mul_signed && operand_a[DATA_BITS-1]}}, operand_a};
  assign b_ext  = {{DATA_BITS{mul_signed && operand_b[DATA_BITS-1]}}, operand_b};
  assign prod_d = a_ext * b_ext;

  hilo_muldiv_unit_divider #(.DATA_BITS(DATA_BITS)) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .is_signed (op == HILO_OP_DIV),
    .abort     (flush),
    .dividend  (operand_a),
    .divisor   (operand_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul_op(op)) state_d = ST_MUL;
        else if (div_start)          state_d = ST_DIV;
      end
      ST_MUL:  if (flush || cnt_q == MUL_LAST) state_d = ST_IDLE;
      ST_DIV:  if (flush || div_valid)         state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              HILO_OP_MTHI:  hi <= operand_a;
              HILO_OP_MTLO:  lo <= operand_a;
              HILO_OP_MULT,
              HILO_OP_MULTU: begin
                prod_q <= prod_d;
                cnt_q  <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (flush) begin
            cnt_q <= '0;
          end else if (cnt_q == MUL_LAST) begin
            {hi, lo} <= prod_q;
            done     <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DIV: begin
          if (!flush && div_valid) begin
            hi   <= div_rem;
            lo   <= div_quo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: an arithmetic reference model of the HI/LO unit is
// compared every cycle, plus directed vectors with hand-computed results.
module tb_hilo_muldiv_unit;
  import hilo_muldiv_unit_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  hilo_muldiv_unit #(.DATA_BITS(W), .MUL_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (a),
    .operand_b (b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} computed with plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    case (o)
      HILO_OP_MULT:  return 64'(longint'($signed(x)) * longint'($signed(y)));
      HILO_OP_MULTU: return 64'(x) * 64'(y);
      HILO_OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
      end
      HILO_OP_DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_done = 1'b0;
  int           m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            {m_hi, m_lo} = {p_hi, p_lo};
            m_done = 1'b1;
          end
        end
      end else if (start && !flush) begin
        case (op)
          HILO_OP_MTHI: m_hi = a;
          HILO_OP_MTLO: m_lo = a;
          HILO_OP_MULT, HILO_OP_MULTU: begin
            {p_hi, p_lo} = ref_result(op, a, b);
            m_left = LAT;
          end
          HILO_OP_DIV, HILO_OP_DIVU: begin
            {p_hi, p_lo} = ref_result(op, a, b);
            m_left = W + 1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk)
    check("cycle", {busy, done, hi, lo}, {m_left > 0, m_done, m_hi, m_lo});

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, seen, n;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, hi, lo}, 66'h0);
    rst_n = 1'b1;

    run_op(HILO_OP_MULT, 32'hFFFF_FFFD, 32'd7, cyc);
    check("mult_latency", 66'(cyc), 66'd3);
    check("mult_done", 66'(done), 66'd1);
    check("mult_result", 66'({hi, lo}), 66'h0_FFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    check("mult_done_pulse", 66'(done), 66'd0);

    run_op(HILO_OP_MULTU, 32'hFFFF_FFFD, 32'd7, cyc);
    check("multu_result", 66'({hi, lo}), 66'h0_0000_0006_FFFF_FFEB);

    run_op(HILO_OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_latency", 66'(cyc), 66'd33);
    check("div_done", 66'(done), 66'd1);
    check("div_neg", 66'({hi, lo}), 66'h0_FFFF_FFFF_FFFF_FFFD);

    run_op(HILO_OP_DIVU, 32'd7, 32'd0, cyc);
    check("divu_by_zero", 66'({hi, lo}), 66'h0_0000_0007_FFFF_FFFF);
    run_op(HILO_OP_DIV, 32'hFFFF_FFF9, 32'd0, cyc);
    check("div_by_zero", 66'({hi, lo}), 66'h0_FFFF_FFF9_FFFF_FFFF);
    run_op(HILO_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("div_overflow", 66'({hi, lo}), 66'h0_0000_0000_8000_0000);
    run_op(HILO_OP_DIV, 32'd100, 32'd7, cyc);
    check("div_pos", 66'({hi, lo}), 66'h0_0000_0002_0000_000E);

    // Flush an in-flight divide: HI/LO keep 2/14, no done pulse follows.
    @(negedge clk);
    start = 1'b1; op = HILO_OP_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 66'(busy), 66'd0);
    check("flush_keep", 66'({hi, lo}), 66'h0_0000_0002_0000_000E);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("flush_no_done", 66'(seen), 66'd0);

    // start together with flush is dropped.
    start = 1'b1; flush = 1'b1; op = HILO_OP_MTHI; a = 32'hDEAD;
    @(negedge clk);
    op = HILO_OP_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start_flush_busy", 66'(busy), 66'd0);
    check("start_flush_keep", 66'(hi), 66'h2);

    start = 1'b1; op = HILO_OP_MTHI; a = 32'h1234;
    @(negedge clk);
    check("mthi_busy", 66'(busy), 66'd0);
    op = HILO_OP_MTLO; a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", 66'(busy), 66'd0);
    check("mthi_mtlo", 66'({hi, lo}), 66'h0_0000_1234_0000_5678);

    // A start raised while busy is ignored.
    start = 1'b1; op = HILO_OP_MULT; a = 32'd5; b = 32'd6;
    @(negedge clk);
    op = HILO_OP_MTHI; a = 32'hBAD;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("start_while_busy", 66'({hi, lo}), 66'h0_0000_0000_0000_001E);

    start = 1'b1; op = 3'd7; a = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    check("unknown_op_busy", 66'(busy), 66'd0);
    check("unknown_op_keep", 66'({hi, lo}), 66'h0_0000_0000_0000_001E);

    // Held start: back-to-back multiplies accepted right after each commit.
    start = 1'b1; op = HILO_OP_MULTU; a = 32'd2; b = 32'd3;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    start = 1'b0;
    check("back_to_back_dones", 66'(seen), 66'd3);
    repeat (5) @(negedge clk);
    check("back_to_back", 66'({hi, lo}), 66'h0_0000_0000_0000_0006);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; op = HILO_OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {busy, done, hi, lo}, 66'h0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (6000) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      op    = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
      flush = ($urandom_range(0, 49) == 0);
    end
    start = 1'b0; flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
